// File: rtl/beta_pkg.sv
// Shared definitions for the Beta register-file slice.
// Holds datapath/address widths, the hardwired-zero register index,
// the register address type and the register-file state encoding.
package beta_pkg;

    localparam int REG_AW = 5;
    localparam int DW     = 32;
    localparam int NREGS  = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd31;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/reg_file_if.sv
// Bus bundle between decode / write-back (master) and the register file (slave).
// Signals:
//   ra_addr/ra_data, rb_addr/rb_data : two combinational read ports
//   rf_w_data/rf_w_addr/rf_we        : write-back commit port
//   claim_en/claim_addr              : decode destination claim
//   busy_a/busy_b                    : pending-write status of ra_addr/rb_addr
//   ready                            : clear sequence done
interface rf_if;
    import beta_pkg::*;

    reg_addr_t         ra_addr;
    logic [DW-1:0]     ra_data;
    reg_addr_t         rb_addr;
    logic [DW-1:0]     rb_data;
    logic [DW-1:0]     rf_w_data;
    reg_addr_t         rf_w_addr;
    logic              rf_we;
    logic              claim_en;
    reg_addr_t         claim_addr;
    logic              busy_a;
    logic              busy_b;
    logic              ready;

    modport master (
        output ra_addr, rb_addr, rf_w_data, rf_w_addr, rf_we, claim_en, claim_addr,
        input  ra_data, rb_data, busy_a, busy_b, ready
    );

    modport slave (
        input  ra_addr, rb_addr, rf_w_data, rf_w_addr, rf_we, claim_en, claim_addr,
        output ra_data, rb_data, busy_a, busy_b, ready
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst                : clock, synchronous active-high clear of all bits
//   claim_en, claim_addr    : set the bit of a newly claimed destination
//   rel_en, rel_addr        : clear the bit when write-back commits
//   look_a_addr, look_b_addr: lookup addresses
//   busy_a, busy_b          : lookup results, masked by a same-cycle release
module rf_scoreboard
    import beta_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      claim_en,
    input  reg_addr_t claim_addr,
    input  logic      rel_en,
    input  reg_addr_t rel_addr,
    input  reg_addr_t look_a_addr,
    input  reg_addr_t look_b_addr,
    output logic      busy_a,
    output logic      busy_b
);

    logic [NREGS-1:0] bits_r;
    logic [NREGS-1:0] bits_nxt_s;
    logic             busy_a_s;
    logic             busy_b_s;

    // Next busy vector: release first, then claim, so a simultaneous claim
    // from the younger instruction wins over the older instruction's release.
    always_comb begin
        bits_nxt_s = bits_r;
        if (rel_en) begin
            bits_nxt_s[rel_addr] = 1'b0;
        end else begin
            bits_nxt_s = bits_nxt_s;
        end
        if (claim_en) begin
            bits_nxt_s[claim_addr] = 1'b1;
        end else begin
            bits_nxt_s = bits_nxt_s;
        end
        bits_nxt_s[ZERO_REG] = 1'b0;
    end

    // Busy vector register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            bits_r <= {NREGS{1'b0}};
        end else begin
            bits_r <= bits_nxt_s;
        end
    end

    // Lookups: a release in this cycle already makes the operand available,
    // matching the read-port bypass.
    always_comb begin
        busy_a_s = bits_r[look_a_addr] & ~(rel_en & (rel_addr == look_a_addr));
        busy_b_s = bits_r[look_b_addr] & ~(rel_en & (rel_addr == look_b_addr));
    end

    assign busy_a = busy_a_s;
    assign busy_b = busy_b_s;

endmodule

// File: rtl/reg_file.sv
// Beta register file with write bypass, hardwired zero register,
// post-reset clear sequencer and pending-write scoreboard.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset; restarts the clear sequence
//   bus  : rf_if slave (read ports, write-back port, claim port, busy, ready)
module reg_file
    import beta_pkg::*;
(
    input  logic clk,
    input  logic rst,
    rf_if.slave  bus
);

    // Encoding matches rf_state_t in beta_pkg.
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Last entry zeroed by the clear sequence; the zero register is skipped.
    localparam reg_addr_t LAST_CLR = ZERO_REG - 5'd1;

    logic [0:0]    state_r;
    reg_addr_t     clr_cnt_r;
    logic          ready_r;
    logic [DW-1:0] regs_r [NREGS];

    logic          run_s;
    logic          arr_we_s;
    reg_addr_t     arr_addr_s;
    logic [DW-1:0] arr_data_s;
    logic [DW-1:0] ra_data_s;
    logic [DW-1:0] rb_data_s;
    logic          claim_s;
    logic          rel_s;
    logic          busy_a_s;
    logic          busy_b_s;

    assign run_s = (state_r == ST_RUN);

    // Clear/run sequencer; ready is registered and rises with the RUN state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= 5'd0;
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + 5'd1;
                    if (clr_cnt_r == LAST_CLR) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_CLEAR;
                        ready_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_r   <= ST_RUN;
                    clr_cnt_r <= clr_cnt_r;
                    ready_r   <= 1'b1;
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_cnt_r <= 5'd0;
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    // Single array write port: clear sequencer owns it in CLEAR, write-back in RUN.
    always_comb begin
        arr_we_s   = 1'b0;
        arr_addr_s = clr_cnt_r;
        arr_data_s = {DW{1'b0}};
        if (rst) begin
            arr_we_s = 1'b0;
        end else if (!run_s) begin
            arr_we_s   = 1'b1;
            arr_addr_s = clr_cnt_r;
            arr_data_s = {DW{1'b0}};
        end else if (bus.rf_we && (bus.rf_w_addr != ZERO_REG)) begin
            arr_we_s   = 1'b1;
            arr_addr_s = bus.rf_w_addr;
            arr_data_s = bus.rf_w_data;
        end else begin
            arr_we_s = 1'b0;
        end
    end

    // Register array storage; cleared by the sequencer rather than by reset.
    always_ff @(posedge clk) begin
        if (arr_we_s) begin
            regs_r[arr_addr_s] <= arr_data_s;
        end
    end

    // Read port A: zero during clear and for the zero register, then bypass, then array.
    always_comb begin
        ra_data_s = {DW{1'b0}};
        if (!run_s || (bus.ra_addr == ZERO_REG)) begin
            ra_data_s = {DW{1'b0}};
        end else if (bus.rf_we && (bus.rf_w_addr == bus.ra_addr)) begin
            ra_data_s = bus.rf_w_data;
        end else begin
            ra_data_s = regs_r[bus.ra_addr];
        end
    end

    // Read port B: identical priority to port A, fully independent.
    always_comb begin
        rb_data_s = {DW{1'b0}};
        if (!run_s || (bus.rb_addr == ZERO_REG)) begin
            rb_data_s = {DW{1'b0}};
        end else if (bus.rf_we && (bus.rf_w_addr == bus.rb_addr)) begin
            rb_data_s = bus.rf_w_data;
        end else begin
            rb_data_s = regs_r[bus.rb_addr];
        end
    end

    // Traffic is ignored until the clear sequence finishes.
    assign claim_s = bus.claim_en & run_s;
    assign rel_s   = bus.rf_we & run_s;

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .claim_en    (claim_s),
        .claim_addr  (bus.claim_addr),
        .rel_en      (rel_s),
        .rel_addr    (bus.rf_w_addr),
        .look_a_addr (bus.ra_addr),
        .look_b_addr (bus.rb_addr),
        .busy_a      (busy_a_s),
        .busy_b      (busy_b_s)
    );

    assign bus.ra_data = ra_data_s;
    assign bus.rb_data = rb_data_s;
    assign bus.busy_a  = busy_a_s & run_s;
    assign bus.busy_b  = busy_b_s & run_s;
    assign bus.ready   = ready_r;

endmodule
